alu_share_sched: RTL and testbench

- Shares one integer add/shift-add/sub/extension datapath between two issue queues (requester 0 and requester 1).
- Round-robin arbitration: at most one operation per cycle is granted to the datapath.
- Each result is registered into a 2-entry in-order result queue.
- The queue drains to the writeback/bypass stage over a valid/ready handshake.
- Sits between the integer reservation stations and the register-file writeback port.

---
 rtl/alu_share_sched.sv | 140 ++++++++++++++
 tb/tb_alu_share_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_share_sched: round-robin shared integer ALU with 2-entry result queue    |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module alu_share_sched #(
  parameter int TAG_W = 6
) (
  input  logic             cpu_clock_i,
  input  logic             cpu_reset_ni,
  input  logic             flush_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [31:0]      req0_a_i,
  input  logic [31:0]      req0_b_i,
  input  logic [3:0]       req0_op_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [31:0]      req1_a_i,
  input  logic [31:0]      req1_b_i,
  input  logic [3:0]       req1_op_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_data_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic             res_src_o,
  output logic             res_illegal_o
);

  // Queue entry layout: {illegal, src, tag, data}
  localparam int ENTRY_W = 34 + TAG_W;

  logic               rr_ptr;
  logic [1:0]         count;
  logic [ENTRY_W-1:0] head_q;
  logic [ENTRY_W-1:0] tail_q;
  logic [ENTRY_W-1:0] new_entry;

  logic               pop;
  logic               space;
  logic               allow;
  logic               grant0;
  logic               grant1;
  logic               push;

  logic [31:0]        op_a;
  logic [31:0]        op_b;
  logic [3:0]         op_code;
  logic [TAG_W-1:0]   op_tag;
  logic [31:0]        alu_res;
  logic               alu_ill;

  assign res_valid_o = (count != 2'd0);
  assign pop         = res_valid_o & res_ready_i;
  assign space       = (count < 2'd2) | pop;
  // Ready is held low while reset is asserted, even though count is already 0.
  assign allow       = space & ~flush_i & cpu_reset_ni;

  assign grant0 = allow & req0_valid_i & (~req1_valid_i | ~rr_ptr);
  assign grant1 = allow & req1_valid_i & ~grant0;
  assign push   = grant0 | grant1;

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  assign op_a    = grant1 ? req1_a_i   : req0_a_i;
  assign op_b    = grant1 ? req1_b_i   : req0_b_i;
  assign op_code = grant1 ? req1_op_i  : req0_op_i;
  assign op_tag  = grant1 ? req1_tag_i : req0_tag_i;

  always_comb begin
    alu_res = 32'd0;
    alu_ill = 1'b0;
    case (op_code)
      4'b0000: alu_res = op_a + op_b;
      4'b0001: alu_res = {op_a[30:0], 1'b0} + op_b;
      4'b0010: alu_res = {op_a[29:0], 2'b0} + op_b;
      4'b0011: alu_res = {op_a[28:0], 3'b0} + op_b;
      4'b0100: alu_res = op_a - op_b;
      4'b1000: alu_res = {{24{op_a[7]}}, op_a[7:0]};
      4'b1001: alu_res = {{16{op_a[15]}}, op_a[15:0]};
      4'b1010: alu_res = {16'd0, op_a[15:0]};
      default: alu_ill = 1'b1;
    endcase
  end

  assign new_entry = {alu_ill, grant1, op_tag, alu_res};

  always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
    if (!cpu_reset_ni) begin
      rr_ptr <= 1'b0;
    end else if (push) begin
      rr_ptr <= ~grant1;
    end
  end

  // Head always sits in head_q; a pop shifts the tail forward.
  always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
    if (!cpu_reset_ni) begin
      count  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else if (flush_i) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_q <= new_entry;
          end else begin
            tail_q <= new_entry;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_q <= new_entry;
          end else begin
            head_q <= tail_q;
            tail_q <= new_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_data_o    = head_q[31:0];
  assign res_tag_o     = head_q[32 +: TAG_W];
  assign res_src_o     = head_q[32 + TAG_W];
  assign res_illegal_o = head_q[33 + TAG_W];

endmodule
`default_nettype wire

// File: tb/tb_alu_share_sched.sv
`default_nettype none
// Bench for alu_share_sched: directed scenarios followed by randomized traffic
// checked against a queue-based reference model.
module tb_alu_share_sched;

  localparam int TAG_W = 6;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             v0, v1, rdy0, rdy1;
  logic [31:0]      a0, b0, a1, b1;
  logic [3:0]       op0, op1;
  logic [TAG_W-1:0] tag0, tag1;
  logic             res_valid, res_ready, res_src, res_illegal;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;

  alu_share_sched #(.TAG_W(TAG_W)) dut (
    .cpu_clock_i   (clk),
    .cpu_reset_ni  (rst_n),
    .flush_i       (flush),
    .req0_valid_i  (v0),
    .req0_ready_o  (rdy0),
    .req0_a_i      (a0),
    .req0_b_i      (b0),
    .req0_op_i     (op0),
    .req0_tag_i    (tag0),
    .req1_valid_i  (v1),
    .req1_ready_o  (rdy1),
    .req1_a_i      (a1),
    .req1_b_i      (b1),
    .req1_op_i     (op1),
    .req1_tag_i    (tag1),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .res_data_o    (res_data),
    .res_tag_o     (res_tag),
    .res_src_o     (res_src),
    .res_illegal_o (res_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      d;
    logic [TAG_W-1:0] t;
    logic             s;
    logic             il;
  } ent_t;

  ent_t mq[$];
  logic mptr;
  int   n_cmp;
  int   n_bad;
  logic obs_r0, obs_r1, obs_v;
  logic exp_g0, exp_g1;

  function automatic ent_t model_op(input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] op, input logic [TAG_W-1:0] t,
                                    input logic s);
    ent_t   e;
    byte    sb;
    shortint sh;
    e.t = t; e.s = s; e.il = 1'b0; e.d = 32'd0;
    sb = a[7:0];
    sh = a[15:0];
    case (op)
      4'd0:             e.d = a + b;
      4'd1, 4'd2, 4'd3: e.d = a * (32'd1 << op) + b;
      4'd4:             e.d = a - b;
      4'd8:             e.d = int'(sb);
      4'd9:             e.d = int'(sh);
      4'd10:            e.d = a % 32'h0001_0000;
      default:          e.il = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs at negedge, check, then advance the model.
  task automatic cycle(input logic iv0, input logic [31:0] ia0, input logic [31:0] ib0,
                       input logic [3:0] iop0, input logic [TAG_W-1:0] it0,
                       input logic iv1, input logic [31:0] ia1, input logic [31:0] ib1,
                       input logic [3:0] iop1, input logic [TAG_W-1:0] it1,
                       input logic rr, input logic fl);
    logic sp;
    v0 = iv0; a0 = ia0; b0 = ib0; op0 = iop0; tag0 = it0;
    v1 = iv1; a1 = ia1; b1 = ib1; op1 = iop1; tag1 = it1;
    res_ready = rr; flush = fl;
    #2;
    sp = (mq.size() < 2) || (mq.size() > 0 && rr);
    exp_g0 = 1'b0; exp_g1 = 1'b0;
    if (sp && !fl) begin
      if (iv0 && (!iv1 || mptr == 1'b0)) exp_g0 = 1'b1;
      else if (iv1)                      exp_g1 = 1'b1;
    end
    obs_r0 = rdy0; obs_r1 = rdy1; obs_v = res_valid;
    chk("ready0", rdy0, exp_g0);
    chk("ready1", rdy1, exp_g1);
    chk("res_valid", res_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("res_data", res_data, mq[0].d);
      chk("res_tag", res_tag, mq[0].t);
      chk("res_src", res_src, mq[0].s);
      chk("res_illegal", res_illegal, mq[0].il);
    end
    @(posedge clk);
    if (mq.size() > 0 && rr) void'(mq.pop_front());
    if (fl) mq.delete();
    if (exp_g0) begin mq.push_back(model_op(ia0, ib0, iop0, it0, 1'b0)); mptr = 1'b1; end
    if (exp_g1) begin mq.push_back(model_op(ia1, ib1, iop1, it1, 1'b1)); mptr = 1'b0; end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  logic             p0_v, p1_v;
  logic [31:0]      p0_a, p0_b, p1_a, p1_b;
  logic [3:0]       p0_op, p1_op;
  logic [TAG_W-1:0] p0_t, p1_t;
  int               ngr;

  initial begin
    n_cmp = 0; n_bad = 0; mptr = 1'b0;
    rst_n = 1'b0; flush = 1'b0; res_ready = 1'b0;
    v0 = 1'b1; a0 = 0; b0 = 0; op0 = 0; tag0 = 0;
    v1 = 1'b0; a1 = 0; b1 = 0; op1 = 0; tag1 = 0;
    // Reset state, with a request presented during reset
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready0", rdy0, 1'b0);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_tag", res_tag, 0);
    chk("rst_src", res_src, 1'b0);
    chk("rst_illegal", res_illegal, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single add and the directed opcode set
    cycle(1, 32'h5, 32'h3, 4'b0000, 6'h11, 0, 0, 0, 0, 0, 1, 0);
    chk("add_valid", res_valid, 1'b1);
    chk("add_data", res_data, 32'h8);
    chk("add_tag", res_tag, 6'h11);
    chk("add_src", res_src, 1'b0);
    chk("add_ill", res_illegal, 1'b0);
    cycle(0, 0, 0, 0, 0, 1, 32'h10, 32'h1, 4'b0011, 6'h05, 1, 0);
    chk("sh3add_data", res_data, 32'h81);
    chk("sh3add_src", res_src, 1'b1);
    cycle(1, 32'h0, 32'h1, 4'b0100, 6'h06, 0, 0, 0, 0, 0, 1, 0);
    chk("sub_data", res_data, 32'hFFFF_FFFF);
    cycle(1, 32'h80, 32'h1234, 4'b1000, 6'h07, 0, 0, 0, 0, 0, 1, 0);
    chk("sextb_data", res_data, 32'hFFFF_FF80);
    cycle(1, 32'h1, 32'h2, 4'b1011, 6'h08, 0, 0, 0, 0, 0, 1, 0);
    chk("illegal_data", res_data, 32'h0);
    chk("illegal_flag", res_illegal, 1'b1);
    cycle(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'h5, 4'b1010, 6'h09, 1, 0);
    chk("zexth_data", res_data, 32'h0000_BEEF);
    idle(2);

    // Fairness: pointer now favours requester 0
    for (int i = 0; i < 6; i++) begin
      cycle(1, 32'(i), 32'h100, 4'b0000, 6'(i), 1, 32'(i), 32'h200, 4'b0001, 6'(i + 8), 1, 0);
      chk("fair_grant0", obs_r0, (i % 2) == 0);
    end
    idle(3);

    // Backpressure: only two grants fit, then a pop frees exactly one slot
    ngr = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h11 + 32'(i), 32'h1, 4'b0000, 6'h21, 1, 32'h22 + 32'(i), 32'h2, 4'b0100, 6'h22, 0, 0);
      ngr += int'(obs_r0) + int'(obs_r1);
    end
    chk("bp_grants", ngr, 2);
    chk("bp_blocked", obs_r0 | obs_r1, 1'b0);
    cycle(1, 32'h33, 32'h1, 4'b0000, 6'h23, 1, 32'h44, 32'h2, 4'b0100, 6'h24, 1, 0);
    chk("bp_one_grant", int'(obs_r0) + int'(obs_r1), 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("bp_still_full", obs_v, 1'b1);
    idle(3);

    // Flush with two queued entries
    cycle(1, 32'h1, 32'h1, 4'b0000, 6'h31, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 32'h2, 32'h2, 4'b0000, 6'h32, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 32'h3, 32'h3, 4'b0000, 6'h33, 0, 0, 0, 0, 0, 0, 1);
    chk("flush_nogrant", obs_r0, 1'b0);
    cycle(1, 32'h3, 32'h3, 4'b0000, 6'h33, 0, 0, 0, 0, 0, 1, 0);
    chk("flush_empty", obs_v, 1'b0);
    chk("flush_regrant", obs_r0, 1'b1);
    idle(2);

    // Asynchronous reset with two entries queued and the pointer at 1
    cycle(1, 32'h7, 32'h1, 4'b0000, 6'h3A, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 32'h8, 32'h1, 4'b0000, 6'h3B, 0, 0, 0, 0, 0, 0, 0);
    v0 = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", res_valid, 1'b0);
    chk("arst_data", res_data, 32'd0);
    chk("arst_ready0", rdy0, 1'b0);
    mq.delete();
    mptr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 32'h9, 32'h1, 4'b0000, 6'h01, 1, 32'hA, 32'h1, 4'b0000, 6'h02, 1, 0);
    chk("arst_first_grant0", obs_r0, 1'b1);
    idle(2);

    // Randomized traffic; requesters hold operands until granted
    p0_v = 1'b0; p1_v = 1'b0;
    p0_a = 0; p0_b = 0; p0_op = 0; p0_t = 0;
    p1_a = 0; p1_b = 0; p1_op = 0; p1_t = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0_v && $urandom_range(0, 3) != 0) begin
        p0_v = 1'b1; p0_a = $urandom; p0_b = $urandom;
        p0_op = 4'($urandom_range(0, 15)); p0_t = 6'($urandom);
      end
      if (!p1_v && $urandom_range(0, 3) != 0) begin
        p1_v = 1'b1; p1_a = $urandom; p1_b = $urandom;
        p1_op = 4'($urandom_range(0, 15)); p1_t = 6'($urandom);
      end
      cycle(p0_v, p0_a, p0_b, p0_op, p0_t, p1_v, p1_a, p1_b, p1_op, p1_t,
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      if (exp_g0) p0_v = 1'b0;
      if (exp_g1) p1_v = 1'b0;
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
